// File: rtl/writeback_regfile_if.sv
// writeback_regfile_if: MEM/WB writeback inputs and register-read outputs.
interface writeback_regfile_if #(parameter int CNT_W = 16) ();
    logic [15:0] MemData, Imm970s, PCImmInc, ALUOut, PCInc, RFOut2, IR;
    logic [2:0] WriteAdd, R7WriteSelect, RdAdd1, RdAdd2;
    logic [1:0] RegWriteSelect, CCR, CCROut;
    logic WriteRF, WriteR7, CCRWrite;
    logic [15:0] RdData1, RdData2, R7Out;
    logic [CNT_W-1:0] RetireCount;
    modport master(
        output MemData, Imm970s, PCImmInc, ALUOut, PCInc, RFOut2, IR, WriteAdd, R7WriteSelect,
               RdAdd1, RdAdd2, RegWriteSelect, CCR, WriteRF, WriteR7, CCRWrite,
        input  RdData1, RdData2, R7Out, CCROut, RetireCount
    );
    modport slave(
        input  MemData, Imm970s, PCImmInc, ALUOut, PCInc, RFOut2, IR, WriteAdd, R7WriteSelect,
               RdAdd1, RdAdd2, RegWriteSelect, CCR, WriteRF, WriteR7, CCRWrite,
        output RdData1, RdData2, R7Out, CCROut, RetireCount
    );
endinterface

// File: rtl/writeback_regfile.sv
// writeback_regfile: 8x16 register file, CCR and retire counter with write-through read bypass.
module writeback_regfile #(
    parameter logic [15:0] NOP_IR = 16'hF000,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic reset,
    writeback_regfile_if.slave wb
);
    logic [15:0] regs [8];
    logic [1:0] ccrReg;
    logic [CNT_W-1:0] retireCnt;
    logic [15:0] rfData, r7Data;
    logic live, rfWe, r7We, ccrWe;
    assign live = !reset && wb.IR != NOP_IR;
    assign rfData = wb.RegWriteSelect == 2'd0 ? wb.ALUOut :
                    wb.RegWriteSelect == 2'd1 ? wb.MemData :
                    wb.RegWriteSelect == 2'd2 ? wb.PCInc : wb.Imm970s;
    assign r7Data = wb.R7WriteSelect == 3'd0 ? wb.ALUOut :
                    wb.R7WriteSelect == 3'd1 ? wb.MemData :
                    wb.R7WriteSelect == 3'd2 ? wb.PCInc :
                    wb.R7WriteSelect == 3'd3 ? wb.Imm970s :
                    wb.R7WriteSelect == 3'd4 ? wb.PCImmInc :
                    wb.R7WriteSelect == 3'd5 ? wb.RFOut2 : 16'h0000;
    // reserved R7 selects (11x) suppress the R7 write entirely
    assign rfWe = live && wb.WriteRF;
    assign r7We = live && wb.WriteR7 && wb.R7WriteSelect[2:1] != 2'b11;
    assign ccrWe = live && wb.CCRWrite;
    // bypass priority mirrors commit order: R7 path over RF path over stored value
    assign wb.RdData1 = r7We && wb.RdAdd1 == 3'd7 ? r7Data :
                        rfWe && wb.RdAdd1 == wb.WriteAdd ? rfData : regs[wb.RdAdd1];
    assign wb.RdData2 = r7We && wb.RdAdd2 == 3'd7 ? r7Data :
                        rfWe && wb.RdAdd2 == wb.WriteAdd ? rfData : regs[wb.RdAdd2];
    assign wb.R7Out = r7We ? r7Data : rfWe && wb.WriteAdd == 3'd7 ? rfData : regs[7];
    assign wb.CCROut = ccrWe ? wb.CCR : ccrReg;
    assign wb.RetireCount = retireCnt;
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0000;
            ccrReg <= 2'b00;
            retireCnt <= '0;
        end else begin
            if (rfWe) regs[wb.WriteAdd] <= rfData;
            if (r7We) regs[7] <= r7Data;
            if (ccrWe) ccrReg <= wb.CCR;
            if (live) retireCnt <= retireCnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: randomized + directed scoreboard bench against a post-write-state model.
module tb_writeback_regfile;
    localparam int CW = 4;
    localparam logic [15:0] NOP = 16'hF000;
    logic clk = 1'b0;
    logic reset = 1'b1;
    writeback_regfile_if #(.CNT_W(CW)) wb ();
    writeback_regfile #(.NOP_IR(NOP), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .wb(wb));
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rd1, rd2, r7;
        logic [1:0] ccr;
        logic [15:0] cnt;
    } expT;
    expT q[$];
    int checks = 0;
    int errors = 0;
    logic [15:0] m [8];
    logic [1:0] mCcr;
    int mCnt;

    task automatic chk(string n, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", n, act, exp);
        end
    endtask

    // the read ports must show exactly the state the register file holds after this edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            expT e;
            e = q.pop_front();
            chk("RdData1", wb.RdData1, e.rd1);
            chk("RdData2", wb.RdData2, e.rd2);
            chk("R7Out", wb.R7Out, e.r7);
            chk("CCROut", {14'b0, wb.CCROut}, {14'b0, e.ccr});
            chk("RetireCount", {{(16-CW){1'b0}}, wb.RetireCount}, e.cnt);
        end
    end

    task automatic cycle();
        logic [15:0] nm [8];
        logic [15:0] rfSrc [4];
        logic [15:0] r7Src [6];
        logic [1:0] nc;
        bit live;
        expT e;
        nm = m;
        nc = mCcr;
        live = !reset && wb.IR != NOP;
        rfSrc = '{wb.ALUOut, wb.MemData, wb.PCInc, wb.Imm970s};
        r7Src = '{wb.ALUOut, wb.MemData, wb.PCInc, wb.Imm970s, wb.PCImmInc, wb.RFOut2};
        if (live && wb.WriteRF) nm[wb.WriteAdd] = rfSrc[wb.RegWriteSelect];
        if (live && wb.WriteR7 && wb.R7WriteSelect < 3'd6) nm[7] = r7Src[wb.R7WriteSelect];
        if (live && wb.CCRWrite) nc = wb.CCR;
        e.rd1 = nm[wb.RdAdd1];
        e.rd2 = nm[wb.RdAdd2];
        e.r7 = nm[7];
        e.ccr = nc;
        e.cnt = 16'(mCnt);
        q.push_back(e);
        if (reset) begin
            for (int i = 0; i < 8; i++) m[i] = 16'h0000;
            mCcr = 2'b00;
            mCnt = 0;
        end else begin
            m = nm;
            mCcr = nc;
            mCnt = (mCnt + (live ? 1 : 0)) % (1 << CW);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randIn();
        wb.MemData = 16'($urandom); wb.Imm970s = 16'($urandom); wb.PCImmInc = 16'($urandom);
        wb.ALUOut = 16'($urandom); wb.PCInc = 16'($urandom); wb.RFOut2 = 16'($urandom);
        wb.IR = ($urandom_range(0, 3) == 0) ? NOP : 16'($urandom_range(0, 16'hEFFF));
        wb.WriteAdd = 3'($urandom); wb.R7WriteSelect = 3'($urandom);
        wb.RdAdd1 = 3'($urandom); wb.RdAdd2 = 3'($urandom);
        wb.RegWriteSelect = 2'($urandom); wb.CCR = 2'($urandom);
        wb.WriteRF = 1'($urandom); wb.WriteR7 = 1'($urandom); wb.CCRWrite = 1'($urandom);
    endtask

    task automatic idle();
        randIn();
        wb.IR = 16'h1000;
        wb.WriteRF = 1'b0; wb.WriteR7 = 1'b0; wb.CCRWrite = 1'b0;
    endtask

    initial begin
        randIn();
        wb.WriteRF = 1'b1; wb.WriteR7 = 1'b1; wb.CCRWrite = 1'b1; wb.IR = 16'h1111;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) m[i] = 16'h0000;
        mCcr = 2'b00;
        mCnt = 0;
        reset = 1'b0;
        idle(); wb.RdAdd1 = 3'd5; wb.RdAdd2 = 3'd7; cycle();
        idle(); wb.WriteRF = 1'b1; wb.WriteAdd = 3'd3; wb.RegWriteSelect = 2'b01;
        wb.MemData = 16'hBEEF; wb.RdAdd1 = 3'd3; cycle();
        idle(); wb.RdAdd1 = 3'd3; wb.RdAdd2 = 3'd3; cycle();
        idle(); wb.WriteRF = 1'b1; wb.WriteAdd = 3'd7; wb.ALUOut = 16'h0011;
        wb.WriteR7 = 1'b1; wb.R7WriteSelect = 3'b100; wb.PCImmInc = 16'h0040; wb.RdAdd1 = 3'd7; cycle();
        idle(); wb.RdAdd1 = 3'd7; cycle();
        idle(); wb.WriteRF = 1'b1; wb.WriteAdd = 3'd2; wb.RegWriteSelect = 2'b00; wb.ALUOut = 16'h2222; cycle();
        idle(); wb.IR = NOP; wb.WriteRF = 1'b1; wb.WriteAdd = 3'd2; wb.ALUOut = 16'h9999;
        wb.CCRWrite = 1'b1; wb.CCR = 2'b11; wb.RdAdd1 = 3'd2; cycle();
        idle(); wb.RdAdd1 = 3'd2; cycle();
        idle(); wb.WriteR7 = 1'b1; wb.R7WriteSelect = 3'b110; wb.RdAdd2 = 3'd7; cycle();
        idle(); wb.WriteR7 = 1'b1; wb.R7WriteSelect = 3'b111; cycle();
        repeat (20) begin idle(); cycle(); end
        idle(); reset = 1'b1; cycle();
        reset = 1'b0;
        idle(); cycle();
        repeat (400) begin
            randIn();
            reset = ($urandom_range(0, 39) == 0);
            cycle();
        end
        reset = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
